// File: rtl/psram_arb_pkg.sv
// psram_arb_pkg: shared types for the PSRAM arbiter.
//   arb_state_e  - arbiter FSM states
//   GNT_*        - grant encoding reported on psram_arbiter.grant
package psram_arb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitBusy,
        StWaitIdle,
        StDone
    } arb_state_e;

    localparam logic [1:0] GNT_DL  = 2'd0;
    localparam logic [1:0] GNT_CLR = 2'd1;
    localparam logic [1:0] GNT_CPU = 2'd2;
    localparam logic [1:0] GNT_CAS = 2'd3;

endpackage

// File: rtl/psram_arb_prio.sv
// psram_arb_prio: combinational priority encoder for the PSRAM arbiter.
// Order is dl > clr > cpu > cas. Cassette reads are eligible only inside the
// refresh window unless promoted by age, in which case they rank above cpu and
// ignore the window.
// Ports:
//   dl_req, clr_req, cpu_req, cas_req  requester levels
//   cas_window                         cassette slot open
//   age                                cpu grants lost by the pending cas read
//   valid                              at least one eligible requester
//   winner                             GNT_* code of the winner
module psram_arb_prio
    import psram_arb_pkg::*;
#(
    parameter int unsigned AGE_LIMIT = 8,
    parameter bit          AGING_EN  = 1'b0
) (
    input  logic       dl_req,
    input  logic       clr_req,
    input  logic       cpu_req,
    input  logic       cas_req,
    input  logic       cas_window,
    input  logic [7:0] age,
    output logic       valid,
    output logic [1:0] winner
);

    logic cas_promote;
    logic cas_elig;

    assign cas_promote = AGING_EN && ({24'd0, age} >= AGE_LIMIT);
    assign cas_elig    = cas_req && (cas_window || cas_promote);

    always_comb begin
        valid  = 1'b1;
        winner = GNT_DL;
        if (dl_req) begin
            winner = GNT_DL;
        end else if (clr_req) begin
            winner = GNT_CLR;
        end else if (cas_req && cas_promote) begin
            winner = GNT_CAS;
        end else if (cpu_req) begin
            winner = GNT_CPU;
        end else if (cas_elig) begin
            winner = GNT_CAS;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/psram_arbiter.sv
// psram_arbiter: four-way arbiter in front of a single-command PSRAM port.
// Requesters: ioctl download (dl), hard-reset cleanup (clr), CPU, cassette (cas).
// One transaction at a time: IDLE selects, ISSUE strobes mem_rd/mem_we for one
// cycle, WAIT_BUSY/WAIT_IDLE follow mem_ready low then high, DONE pulses the
// winner's ack.
// Ports:
//   clk_sys, reset              clock, asynchronous active-high reset
//   dl_req/ack, dl_addr/din     download writes
//   clr_req/ack, clr_addr       cleanup writes of 8'h00
//   cpu_req/we/ack, addr/din    CPU reads and writes
//   cas_req/ack, cas_addr       cassette reads, gated by cas_window
//   rdata                       data of the last completed read
//   mem_addr/din/rd/we          PSRAM command side
//   mem_dout, mem_ready         PSRAM read data and idle level
//   grant                       owner of current or last transaction (GNT_*)
// Configuration: define PSRAM_ARB_CAS_AGING_EN to let a starved cassette read
// overtake the CPU after AGE_LIMIT lost CPU grants.
module psram_arbiter
    import psram_arb_pkg::*;
#(
    parameter int unsigned AW        = 23,
    parameter int unsigned AGE_LIMIT = 8
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          dl_req,
    output logic          dl_ack,
    input  logic [AW-1:0] dl_addr,
    input  logic [7:0]    dl_din,
    input  logic          clr_req,
    output logic          clr_ack,
    input  logic [AW-1:0] clr_addr,
    input  logic          cpu_req,
    input  logic          cpu_we,
    output logic          cpu_ack,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    input  logic          cas_req,
    output logic          cas_ack,
    input  logic [AW-1:0] cas_addr,
    input  logic          cas_window,
    output logic [7:0]    rdata,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    output logic          mem_rd,
    output logic          mem_we,
    input  logic [7:0]    mem_dout,
    input  logic          mem_ready,
    output logic [1:0]    grant
);

`ifdef PSRAM_ARB_CAS_AGING_EN
    localparam bit AgingEn = 1'b1;
`else
    localparam bit AgingEn = 1'b0;
`endif

    arb_state_e    state_q;
    logic          is_write_q;
    logic          win_valid;
    logic [1:0]    win;
    logic [AW-1:0] sel_addr;
    logic [7:0]    sel_din;
    logic          sel_we;
    logic [7:0]    age;
    logic          take;

    // A winner is only taken while idle and the PSRAM reports ready.
    assign take = (state_q == StIdle) && mem_ready && win_valid;

    psram_arb_prio #(
        .AGE_LIMIT (AGE_LIMIT),
        .AGING_EN  (AgingEn)
    ) u_prio (
        .dl_req     (dl_req),
        .clr_req    (clr_req),
        .cpu_req    (cpu_req),
        .cas_req    (cas_req),
        .cas_window (cas_window),
        .age        (age),
        .valid      (win_valid),
        .winner     (win)
    );

    always_comb begin
        sel_addr = '0;
        sel_din  = 8'h00;
        sel_we   = 1'b0;
        unique case (win)
            GNT_DL: begin
                sel_addr = dl_addr;
                sel_din  = dl_din;
                sel_we   = 1'b1;
            end
            GNT_CLR: begin
                sel_addr = clr_addr;
                sel_din  = 8'h00;
                sel_we   = 1'b1;
            end
            GNT_CPU: begin
                sel_addr = cpu_addr;
                sel_din  = cpu_din;
                sel_we   = cpu_we;
            end
            GNT_CAS: begin
                sel_addr = cas_addr;
                sel_din  = 8'h00;
                sel_we   = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef PSRAM_ARB_CAS_AGING_EN
    logic [7:0] age_q;

    // Counts cpu grants taken while a cassette read waits; saturates at 255.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            age_q <= 8'h00;
        end else if (take) begin
            if (win == GNT_CAS) begin
                age_q <= 8'h00;
            end else if (win == GNT_CPU && cas_req && age_q != 8'hFF) begin
                age_q <= age_q + 8'h01;
            end
        end
    end

    assign age = age_q;
`else
    assign age = 8'h00;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            is_write_q <= 1'b0;
            grant      <= GNT_DL;
            mem_addr   <= '0;
            mem_din    <= 8'h00;
            mem_rd     <= 1'b0;
            mem_we     <= 1'b0;
            rdata      <= 8'h00;
            dl_ack     <= 1'b0;
            clr_ack    <= 1'b0;
            cpu_ack    <= 1'b0;
            cas_ack    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (take) begin
                        grant      <= win;
                        mem_addr   <= sel_addr;
                        mem_din    <= sel_din;
                        is_write_q <= sel_we;
                        // Strobe is registered here so it is high for the ISSUE cycle.
                        mem_we     <= sel_we;
                        mem_rd     <= !sel_we;
                        state_q    <= StIssue;
                    end
                end
                StIssue: begin
                    mem_rd  <= 1'b0;
                    mem_we  <= 1'b0;
                    state_q <= StWaitBusy;
                end
                StWaitBusy: begin
                    if (!mem_ready) begin
                        state_q <= StWaitIdle;
                    end
                end
                StWaitIdle: begin
                    if (mem_ready) begin
                        if (!is_write_q) begin
                            rdata <= mem_dout;
                        end
                        unique case (grant)
                            GNT_DL:  dl_ack  <= 1'b1;
                            GNT_CLR: clr_ack <= 1'b1;
                            GNT_CPU: cpu_ack <= 1'b1;
                            GNT_CAS: cas_ack <= 1'b1;
                            default: ;
                        endcase
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    dl_ack  <= 1'b0;
                    clr_ack <= 1'b0;
                    cpu_ack <= 1'b0;
                    cas_ack <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_psram_arbiter.sv
// tb_psram_arbiter: directed bench for psram_arbiter with a small PSRAM model
// and a scoreboard of expected memory transactions.
module tb_psram_arbiter;
    import psram_arb_pkg::*;

    localparam int unsigned AW = 23;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          dl_req, dl_ack, clr_req, clr_ack, cpu_req, cpu_we, cpu_ack;
    logic          cas_req, cas_ack, cas_window, mem_rd, mem_we, mem_ready;
    logic [AW-1:0] dl_addr, clr_addr, cpu_addr, cas_addr, mem_addr;
    logic [7:0]    dl_din, cpu_din, rdata, mem_din, mem_dout;
    logic [1:0]    grant;
    logic [3:0]    ackv;

    typedef struct packed {
        logic [1:0]    gnt;
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    din;
    } txn_t;

    txn_t exp_q[$];
    txn_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   strobes = 0;
    int   busy_cnt = 0;
    int   s0;
    logic hold_low = 1'b0;
    logic prev_strobe = 1'b0;

    assign ackv = {dl_ack, clr_ack, cpu_ack, cas_ack};

    psram_arbiter #(
        .AW        (AW),
        .AGE_LIMIT (4)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .dl_req     (dl_req),
        .dl_ack     (dl_ack),
        .dl_addr    (dl_addr),
        .dl_din     (dl_din),
        .clr_req    (clr_req),
        .clr_ack    (clr_ack),
        .clr_addr   (clr_addr),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_ack    (cpu_ack),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cas_req    (cas_req),
        .cas_ack    (cas_ack),
        .cas_addr   (cas_addr),
        .cas_window (cas_window),
        .rdata      (rdata),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_rd     (mem_rd),
        .mem_we     (mem_we),
        .mem_dout   (mem_dout),
        .mem_ready  (mem_ready),
        .grant      (grant)
    );

    always #5 clk_sys = ~clk_sys;

    // PSRAM model: busy for three cycles after each command.
    always @(posedge clk_sys) begin
        if (mem_rd || mem_we) busy_cnt <= 3;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign mem_ready = (busy_cnt == 0) && !hold_low;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard side: every command strobe is matched against the queue head.
    always @(negedge clk_sys) begin
        if (!reset && (mem_rd || mem_we)) begin
            strobes++;
            check("strobe_excl", {31'd0, mem_rd & mem_we}, 32'd0);
            check("strobe_width", {31'd0, prev_strobe}, 32'd0);
            check("access_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("txn_grant", {30'd0, grant}, {30'd0, mon_e.gnt});
                check("txn_we", {31'd0, mem_we}, {31'd0, mon_e.we});
                check("txn_addr", {9'd0, mem_addr}, {9'd0, mon_e.addr});
                if (mon_e.we) check("txn_din", {24'd0, mem_din}, {24'd0, mon_e.din});
            end
        end
        prev_strobe = mem_rd | mem_we;
        if (ackv != 4'b0000) begin
            check("ack_onehot", $countones(ackv), 32'd1);
            check("ack_owner", {28'd0, ackv}, {28'd0, 4'b1000 >> grant});
        end
    end

    task automatic wait_ack(input logic [3:0] expv, input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_sys);
            if (ackv != 4'b0000) begin
                seen = 1'b1;
                check(tag, {28'd0, ackv}, {28'd0, expv});
            end
        end
        check({tag, "_seen"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_strobe(input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_sys);
            if (mem_rd || mem_we) seen = 1'b1;
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic push(input logic [1:0] g, input logic we, input logic [AW-1:0] a,
                        input logic [7:0] d);
        txn_t t;
        t.gnt = g; t.we = we; t.addr = a; t.din = d;
        exp_q.push_back(t);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, {30'd0, grant}, 32'd0);
        check({tag, "_rdwe"}, {30'd0, mem_rd, mem_we}, 32'd0);
        check({tag, "_addr"}, {9'd0, mem_addr}, 32'd0);
        check({tag, "_din"}, {24'd0, mem_din}, 32'd0);
        check({tag, "_rdata"}, {24'd0, rdata}, 32'd0);
        check({tag, "_acks"}, {28'd0, ackv}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        {dl_req, clr_req, cpu_req, cpu_we, cas_req, cas_window} = '0;
        dl_addr = '0; clr_addr = '0; cpu_addr = '0; cas_addr = '0;
        dl_din = 8'h00; cpu_din = 8'h00; mem_dout = 8'h00;
        repeat (3) @(negedge clk_sys);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk_sys);

        // Lone cpu read.
        mem_dout = 8'hA5; cpu_addr = 23'h020010; cpu_we = 1'b0;
        push(GNT_CPU, 1'b0, 23'h020010, 8'h00);
        cpu_req = 1'b1;
        wait_ack(4'b0010, "cpu_rd_ack");
        cpu_req = 1'b0;
        check("cpu_rd_grant", {30'd0, grant}, 32'd2);
        check("cpu_rd_rdata", {24'd0, rdata}, 32'hA5);
        @(negedge clk_sys);
        check("cpu_ack_pulse", {28'd0, ackv}, 32'd0);

        // dl and cpu together: dl first.
        dl_addr = 23'h000100; dl_din = 8'h5A;
        cpu_addr = 23'h000123; cpu_din = 8'h3C; cpu_we = 1'b1;
        push(GNT_DL, 1'b1, 23'h000100, 8'h5A);
        push(GNT_CPU, 1'b1, 23'h000123, 8'h3C);
        dl_req = 1'b1; cpu_req = 1'b1;
        wait_ack(4'b1000, "dl_first");
        dl_req = 1'b0;
        check("dl_grant", {30'd0, grant}, 32'd0);
        wait_ack(4'b0010, "cpu_second");
        cpu_req = 1'b0;
        check("cpu_wr_grant", {30'd0, grant}, 32'd2);
        check("rdata_hold", {24'd0, rdata}, 32'hA5);

        // Cassette blocked outside its window.
        cas_addr = 23'h0ABCDE; cas_window = 1'b0; cas_req = 1'b1; mem_dout = 8'h77;
        s0 = strobes;
        repeat (20) @(negedge clk_sys);
        check("cas_blocked", strobes - s0, 32'd0);
        push(GNT_CAS, 1'b0, 23'h0ABCDE, 8'h00);
        cas_window = 1'b1;
        wait_ack(4'b0001, "cas_ack");
        cas_req = 1'b0; cas_window = 1'b0;
        check("cas_rdata", {24'd0, rdata}, 32'h77);
        @(negedge clk_sys);
        check("cas_ack_pulse", {28'd0, ackv}, 32'd0);

        // Cleanup write with a cpu read pending.
        clr_addr = 23'h40FFFF; cpu_addr = 23'h000200; cpu_we = 1'b0; cpu_din = 8'hFF;
        mem_dout = 8'hC3;
        push(GNT_CLR, 1'b1, 23'h40FFFF, 8'h00);
        push(GNT_CPU, 1'b0, 23'h000200, 8'h00);
        clr_req = 1'b1; cpu_req = 1'b1;
        wait_ack(4'b0100, "clr_ack");
        clr_req = 1'b0;
        wait_ack(4'b0010, "cpu_after_clr");
        cpu_req = 1'b0;
        check("cpu_after_clr_rdata", {24'd0, rdata}, 32'hC3);

        // Continuous cpu and cas with the window closed.
        cpu_addr = 23'h000300; cas_addr = 23'h000400; mem_dout = 8'h11;
`ifdef PSRAM_ARB_CAS_AGING_EN
        for (int i = 0; i < 4; i++) push(GNT_CPU, 1'b0, 23'h000300, 8'h00);
        push(GNT_CAS, 1'b0, 23'h000400, 8'h00);
        cpu_req = 1'b1; cas_req = 1'b1;
        for (int i = 0; i < 4; i++) wait_ack(4'b0010, "age_cpu");
        wait_ack(4'b0001, "age_cas");
        cas_req = 1'b0;
        push(GNT_CPU, 1'b0, 23'h000300, 8'h00);
        wait_ack(4'b0010, "age_cpu_after");
        cpu_req = 1'b0;
`else
        for (int i = 0; i < 6; i++) push(GNT_CPU, 1'b0, 23'h000300, 8'h00);
        cpu_req = 1'b1; cas_req = 1'b1;
        for (int i = 0; i < 6; i++) wait_ack(4'b0010, "starve_cpu");
        cpu_req = 1'b0; cas_req = 1'b0;
`endif
        check("loop_rdata", {24'd0, rdata}, 32'h11);
        @(negedge clk_sys);

        // Reset while waiting for the PSRAM to go idle.
        cpu_addr = 23'h000777; mem_dout = 8'h3E;
        push(GNT_CPU, 1'b0, 23'h000777, 8'h00);
        cpu_req = 1'b1;
        wait_strobe("mid_strobe");
        hold_low = 1'b1;
        repeat (3) @(negedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        check_reset_outputs("mid_reset");
        reset = 1'b0;
        push(GNT_CPU, 1'b0, 23'h000777, 8'h00);
        s0 = strobes;
        repeat (10) @(negedge clk_sys);
        check("post_reset_wait", strobes - s0, 32'd0);
        check("post_reset_noack", {28'd0, ackv}, 32'd0);
        hold_low = 1'b0;
        wait_ack(4'b0010, "post_reset_ack");
        cpu_req = 1'b0;
        check("post_reset_rdata", {24'd0, rdata}, 32'h3E);
        repeat (5) @(negedge clk_sys);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
